// File: rtl/if_stage.sv
// Instruction fetch stage: one outstanding imem request, IF/ID register plus a one-entry hold
// buffer, and redirect handling that kills an in-flight response.
package if_stage_pkg;
  typedef struct packed {
    logic [31:0] ir;
    logic [31:0] ia_plus_4;
  } id_params_t;
endpackage

module if_stage
  import if_stage_pkg::*;
#(
  parameter logic [31:0] RESET_VECTOR = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_addr,
  output logic        id_valid,
  input  logic        id_ready,
  output id_params_t  id_params
);

  typedef enum logic [1:0] {StFetch, StWait, StHold} state_e;

  state_e      state;
  logic [31:0] pc;
  logic [31:0] inflight_pc;
  logic [31:0] next_pc;
  logic        kill;
  id_params_t  hold_buf;
  logic        unused_redirect_lsb;

  assign next_pc             = inflight_pc + 32'd4;
  assign imem_req_valid      = rst_n && (state == StFetch) && !redirect_valid;
  assign imem_req_addr       = pc;
  assign unused_redirect_lsb = ^redirect_addr[1:0];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= StFetch;
      pc          <= RESET_VECTOR;
      inflight_pc <= '0;
      kill        <= 1'b0;
      id_valid    <= 1'b0;
      id_params   <= '0;
      hold_buf    <= '0;
    end else begin
      // Consumption clears the register unless a refill below overrides it.
      if (id_valid && id_ready) id_valid <= 1'b0;

      if (redirect_valid) begin
        pc       <= {redirect_addr[31:2], 2'b00};
        id_valid <= 1'b0;
        hold_buf <= '0;
        // A request still in flight must have its response dropped when it arrives.
        if (state == StWait && !imem_rsp_valid) begin
          kill  <= 1'b1;
          state <= StWait;
        end else begin
          kill  <= 1'b0;
          state <= StFetch;
        end
      end else begin
        unique case (state)
          StFetch: begin
            if (imem_req_valid && imem_req_ready) begin
              inflight_pc <= pc;
              state       <= StWait;
            end
          end
          StWait: begin
            if (imem_rsp_valid) begin
              state <= StFetch;
              if (kill) begin
                kill <= 1'b0;
              end else if (!id_valid || id_ready) begin
                id_params <= {imem_rsp_data, next_pc};
                id_valid  <= 1'b1;
                pc        <= next_pc;
              end else begin
                hold_buf <= {imem_rsp_data, next_pc};
                pc       <= next_pc;
                state    <= StHold;
              end
            end
          end
          StHold: begin
            if (id_ready) begin
              id_params <= hold_buf;
              id_valid  <= 1'b1;
              state     <= StFetch;
            end
          end
          default: state <= StFetch;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_if_stage.sv
// Bench for if_stage: directed scenarios plus a randomized run against a transaction-level model.
module tb_if_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        imem_req_valid, imem_req_ready, imem_rsp_valid;
  logic [31:0] imem_req_addr, imem_rsp_data;
  logic        redirect_valid, id_valid, id_ready;
  logic [31:0] redirect_addr;
  logic [63:0] id_params;
  logic        req_valid_w, id_valid_w;
  logic [31:0] req_addr_w;
  logic [63:0] id_params_w;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  if_stage dut (
    .clk(clk), .rst_n(rst_n),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
    .imem_req_addr(imem_req_addr), .imem_rsp_valid(imem_rsp_valid),
    .imem_rsp_data(imem_rsp_data), .redirect_valid(redirect_valid),
    .redirect_addr(redirect_addr), .id_valid(id_valid), .id_ready(id_ready),
    .id_params(id_params)
  );

  if_stage #(.RESET_VECTOR(32'hFFFF_FFFC)) dut_w (
    .clk(clk), .rst_n(rst_n),
    .imem_req_valid(req_valid_w), .imem_req_ready(imem_req_ready),
    .imem_req_addr(req_addr_w), .imem_rsp_valid(imem_rsp_valid),
    .imem_rsp_data(imem_rsp_data), .redirect_valid(redirect_valid),
    .redirect_addr(redirect_addr), .id_valid(id_valid_w), .id_ready(id_ready),
    .id_params(id_params_w)
  );

  task automatic step_clk();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    imem_req_ready = 1'b0; imem_rsp_valid = 1'b0; imem_rsp_data = '0;
    redirect_valid = 1'b0; redirect_addr = '0; id_ready = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    idle_inputs();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; idle_inputs(); imem_req_ready = 1'b1; id_ready = 1'b1;
    step_clk();
    @(negedge clk);
    total++; if (imem_req_valid !== 1'b0) begin bad++; $display("FAIL reset_req_valid got=%b want=0", imem_req_valid); end
    total++; if (id_valid !== 1'b0) begin bad++; $display("FAIL reset_id_valid got=%b want=0", id_valid); end
    total++; if (id_params !== 64'h0) begin bad++; $display("FAIL reset_id_params got=%h want=0", id_params); end
    step_clk();
    rst_n = 1'b1;
    @(negedge clk);
    total++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h0) begin bad++; $display("FAIL reset_first_req got=%b/%h want=1/00000000", imem_req_valid, imem_req_addr); end
    total++; if (req_valid_w !== 1'b1 || req_addr_w !== 32'hFFFF_FFFC) begin bad++; $display("FAIL reset_first_req_w got=%b/%h want=1/fffffffc", req_valid_w, req_addr_w); end
    step_clk();
  endtask

  task automatic test_basic();
    logic [31:0] w [3];
    w[0] = 32'h11; w[1] = 32'h22; w[2] = 32'h33;
    do_reset(); imem_req_ready = 1'b1; id_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      imem_rsp_valid = 1'b0;
      @(negedge clk);
      total++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'(4 * i)) begin bad++; $display("FAIL basic_req[%0d] got=%b/%h want=1/%h", i, imem_req_valid, imem_req_addr, 32'(4 * i)); end
      if (i > 0) begin
        total++; if (id_valid !== 1'b1 || id_params !== {w[i-1], 32'(4 * i)}) begin bad++; $display("FAIL basic_id[%0d] got=%b/%h want=1/%h", i, id_valid, id_params, {w[i-1], 32'(4 * i)}); end
      end
      step_clk();
      imem_rsp_valid = 1'b1; imem_rsp_data = w[i];
      @(negedge clk);
      total++; if (imem_req_valid !== 1'b0 || id_valid !== 1'b0) begin bad++; $display("FAIL basic_wait[%0d] got req=%b id=%b want 0/0", i, imem_req_valid, id_valid); end
      step_clk();
    end
    imem_rsp_valid = 1'b0;
    @(negedge clk);
    total++; if (id_valid !== 1'b1 || id_params !== {32'h33, 32'd12}) begin bad++; $display("FAIL basic_last got=%b/%h want=1/%h", id_valid, id_params, {32'h33, 32'd12}); end
    step_clk();
  endtask

  task automatic test_stall();
    do_reset(); imem_req_ready = 1'b1; id_ready = 1'b0;
    step_clk();
    imem_rsp_valid = 1'b1; imem_rsp_data = 32'h11; step_clk();
    imem_rsp_valid = 1'b0;
    @(negedge clk);
    total++; if (id_valid !== 1'b1 || id_params !== {32'h11, 32'd4}) begin bad++; $display("FAIL stall_first got=%b/%h want=1/%h", id_valid, id_params, {32'h11, 32'd4}); end
    total++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'd4) begin bad++; $display("FAIL stall_req4 got=%b/%h want=1/4", imem_req_valid, imem_req_addr); end
    step_clk();
    imem_rsp_valid = 1'b1; imem_rsp_data = 32'h22; step_clk();
    imem_rsp_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      total++; if (id_valid !== 1'b1 || id_params !== {32'h11, 32'd4} || imem_req_valid !== 1'b0) begin bad++; $display("FAIL stall_hold[%0d] got id=%b/%h req=%b want 1/%h req 0", i, id_valid, id_params, imem_req_valid, {32'h11, 32'd4}); end
      step_clk();
    end
    id_ready = 1'b1;
    @(negedge clk);
    total++; if (id_params !== {32'h11, 32'd4} || imem_req_valid !== 1'b0) begin bad++; $display("FAIL stall_release got=%h req=%b want=%h req 0", id_params, imem_req_valid, {32'h11, 32'd4}); end
    step_clk();
    id_ready = 1'b0;
    @(negedge clk);
    total++; if (id_valid !== 1'b1 || id_params !== {32'h22, 32'd8}) begin bad++; $display("FAIL stall_second got=%b/%h want=1/%h", id_valid, id_params, {32'h22, 32'd8}); end
    total++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'd8) begin bad++; $display("FAIL stall_req8 got=%b/%h want=1/8", imem_req_valid, imem_req_addr); end
    step_clk();
  endtask

  task automatic test_redirect_wait();
    do_reset(); imem_req_ready = 1'b1; id_ready = 1'b0;
    step_clk();
    imem_rsp_valid = 1'b1; imem_rsp_data = 32'h11; step_clk();
    imem_rsp_valid = 1'b0;
    step_clk();
    redirect_valid = 1'b1; redirect_addr = 32'h100;
    @(negedge clk);
    total++; if (imem_req_valid !== 1'b0 || id_valid !== 1'b1) begin bad++; $display("FAIL rdw_cycle got req=%b id=%b want 0/1", imem_req_valid, id_valid); end
    step_clk();
    redirect_valid = 1'b0; imem_rsp_valid = 1'b1; imem_rsp_data = 32'hDEAD_BEEF;
    @(negedge clk);
    total++; if (id_valid !== 1'b0 || imem_req_valid !== 1'b0) begin bad++; $display("FAIL rdw_flush got id=%b req=%b want 0/0", id_valid, imem_req_valid); end
    step_clk();
    imem_rsp_valid = 1'b0;
    @(negedge clk);
    total++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h100 || id_valid !== 1'b0) begin bad++; $display("FAIL rdw_req got=%b/%h id=%b want 1/00000100 id 0", imem_req_valid, imem_req_addr, id_valid); end
    step_clk();
    imem_rsp_valid = 1'b1; imem_rsp_data = 32'h55; step_clk();
    imem_rsp_valid = 1'b0;
    @(negedge clk);
    total++; if (id_valid !== 1'b1 || id_params !== {32'h55, 32'h104}) begin bad++; $display("FAIL rdw_deliver got=%b/%h want=1/%h", id_valid, id_params, {32'h55, 32'h104}); end
    step_clk();
  endtask

  task automatic test_redirect_rsp();
    do_reset(); imem_req_ready = 1'b1; id_ready = 1'b1;
    step_clk();
    imem_rsp_valid = 1'b1; imem_rsp_data = 32'h77; redirect_valid = 1'b1; redirect_addr = 32'h203;
    step_clk();
    imem_rsp_valid = 1'b0; redirect_valid = 1'b0;
    @(negedge clk);
    total++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h200 || id_valid !== 1'b0) begin bad++; $display("FAIL rdr_req got=%b/%h id=%b want 1/00000200 id 0", imem_req_valid, imem_req_addr, id_valid); end
    step_clk();
    imem_rsp_valid = 1'b1; imem_rsp_data = 32'h88; step_clk();
    imem_rsp_valid = 1'b0;
    @(negedge clk);
    total++; if (id_valid !== 1'b1 || id_params !== {32'h88, 32'h204}) begin bad++; $display("FAIL rdr_deliver got=%b/%h want=1/%h", id_valid, id_params, {32'h88, 32'h204}); end
    step_clk();
  endtask

  task automatic test_wrap();
    do_reset(); imem_req_ready = 1'b1; id_ready = 1'b1;
    step_clk();
    imem_rsp_valid = 1'b1; imem_rsp_data = 32'h99; step_clk();
    imem_rsp_valid = 1'b0;
    @(negedge clk);
    total++; if (id_valid_w !== 1'b1 || id_params_w !== {32'h99, 32'h0}) begin bad++; $display("FAIL wrap_id got=%b/%h want=1/%h", id_valid_w, id_params_w, {32'h99, 32'h0}); end
    total++; if (req_valid_w !== 1'b1 || req_addr_w !== 32'h0) begin bad++; $display("FAIL wrap_req got=%b/%h want=1/0", req_valid_w, req_addr_w); end
    step_clk();
  endtask

  task automatic test_reset_mid_wait();
    do_reset(); imem_req_ready = 1'b1; id_ready = 1'b1;
    step_clk();
    rst_n = 1'b0;
    @(negedge clk);
    total++; if (imem_req_valid !== 1'b0) begin bad++; $display("FAIL rmw_in_reset got=%b want=0", imem_req_valid); end
    step_clk();
    rst_n = 1'b1; imem_rsp_valid = 1'b1; imem_rsp_data = 32'hBAD; imem_req_ready = 1'b0;
    step_clk();
    imem_rsp_valid = 1'b0; imem_req_ready = 1'b1;
    @(negedge clk);
    total++; if (id_valid !== 1'b0 || imem_req_valid !== 1'b1 || imem_req_addr !== 32'h0) begin bad++; $display("FAIL rmw_ignore got id=%b req=%b/%h want 0 1/0", id_valid, imem_req_valid, imem_req_addr); end
    step_clk();
    imem_rsp_valid = 1'b1; imem_rsp_data = 32'h42; step_clk();
    imem_rsp_valid = 1'b0;
    @(negedge clk);
    total++; if (id_valid !== 1'b1 || id_params !== {32'h42, 32'd4}) begin bad++; $display("FAIL rmw_deliver got=%b/%h want=1/%h", id_valid, id_params, {32'h42, 32'd4}); end
    step_clk();
  endtask

  // Model: expected instruction stream as a queue, memory as a single pending slot.
  task automatic test_random();
    logic [63:0] q[$];
    logic [31:0] exp_pc = 32'h0;
    logic [31:0] pend_addr = 32'h0;
    bit pending = 1'b0;
    bit killed = 1'b0;
    bit exp_req;
    int delay = 0;
    do_reset();
    for (int n = 0; n < 3000; n++) begin
      redirect_valid = ($urandom_range(0, 15) == 0);
      redirect_addr  = $urandom;
      id_ready       = ($urandom_range(0, 2) != 0);
      imem_req_ready = ($urandom_range(0, 3) != 0);
      imem_rsp_valid = pending && (delay == 0);
      imem_rsp_data  = $urandom;
      @(negedge clk);
      exp_req = !redirect_valid && !pending && (q.size() < 2);
      total++; if (imem_req_valid !== exp_req) begin bad++; $display("FAIL rnd_req_valid n=%0d got=%b want=%b", n, imem_req_valid, exp_req); end
      if (exp_req) begin
        total++; if (imem_req_addr !== exp_pc) begin bad++; $display("FAIL rnd_req_addr n=%0d got=%h want=%h", n, imem_req_addr, exp_pc); end
      end
      total++; if (id_valid !== (q.size() != 0)) begin bad++; $display("FAIL rnd_id_valid n=%0d got=%b want=%b", n, id_valid, q.size() != 0); end
      if (q.size() != 0) begin
        total++; if (id_params !== q[0]) begin bad++; $display("FAIL rnd_id_params n=%0d got=%h want=%h", n, id_params, q[0]); end
      end
      if (q.size() != 0 && id_ready) void'(q.pop_front());
      if (pending && !imem_rsp_valid) delay--;
      if (redirect_valid) begin
        q.delete();
        exp_pc = {redirect_addr[31:2], 2'b00};
        if (imem_rsp_valid) begin pending = 1'b0; killed = 1'b0; end
        else if (pending) killed = 1'b1;
      end else if (imem_rsp_valid) begin
        if (!killed) q.push_back({imem_rsp_data, pend_addr + 32'd4});
        pending = 1'b0; killed = 1'b0;
      end else if (exp_req && imem_req_ready) begin
        pending = 1'b1; pend_addr = exp_pc; exp_pc = exp_pc + 32'd4;
        delay = $urandom_range(0, 3);
      end
      step_clk();
    end
    idle_inputs();
  endtask

  initial begin
    idle_inputs();
    rst_n = 1'b0;
    test_reset();
    test_basic();
    test_stall();
    test_redirect_wait();
    test_redirect_rsp();
    test_wrap();
    test_reset_mid_wait();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/if_stage.md
IF_STAGE -- requirements
Module: if_stage

Interface
REQ-001 SHALL have parameter RESET_VECTOR, default 32'h0000_0000, first fetch address after reset (bits [1:0] SHALL be 0).
REQ-002 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, synchronous, active-low.
REQ-004 SHALL have port imem_req_valid  output  1  fetch request valid.
REQ-005 SHALL have port imem_req_ready  input  1  memory accepts request.
REQ-006 SHALL have port imem_req_addr  output  32  fetch address, word aligned.
REQ-007 SHALL have port imem_rsp_valid  input  1  fetch response valid; always accepted, no backpressure.
REQ-008 SHALL have port imem_rsp_data  input  32  fetched instruction word.
REQ-009 SHALL have port redirect_valid  input  1  control-flow redirect from ID/EX.
REQ-010 SHALL have port redirect_addr  input  32  redirect target; bits [1:0] ignored, treated as 0.
REQ-011 SHALL have port id_valid  output  1  IF/ID register holds a valid instruction.
REQ-012 SHALL have port id_ready  input  1  decode consumes IF/ID register this cycle.
REQ-013 SHALL have port id_params  output  id_params_t (64)  registered {ir, ia_plus_4} toward decode.

Function
REQ-014 SHALL keep at most one memory request outstanding.
REQ-015 SHALL implement states FETCH, WAIT, HOLD.
REQ-016 FETCH: imem_req_valid = ~redirect_valid, imem_req_addr = pc; on valid&ready latch inflight_pc = pc, go WAIT.
REQ-017 WAIT: imem_req_valid = 0; stay until imem_rsp_valid.
REQ-018 WAIT + rsp, kill clear, IF/ID empty or id_ready: IF/ID <= {rsp_data, inflight_pc+4}, id_valid <= 1, pc <= inflight_pc+4, go FETCH.
REQ-019 WAIT + rsp, kill clear, id_valid=1 and id_ready=0: capture {rsp_data, inflight_pc+4} into hold buffer, pc <= inflight_pc+4, go HOLD.
REQ-020 HOLD: imem_req_valid = 0; on id_ready move hold buffer into IF/ID (id_valid stays 1), go FETCH.
REQ-021 Consumption (id_valid & id_ready) with no refill SHALL clear id_valid next cycle.
REQ-022 Fetch-to-decode latency: request accepted in cycle N with response in N+1 gives id_valid=1 in N+2.
REQ-023 ia_plus_4 SHALL be inflight_pc + 4 modulo 2^32 (32'hFFFF_FFFC yields 32'h0000_0000).
REQ-024 redirect_valid SHALL take priority over every other event in the same cycle.
REQ-025 On redirect: pc <= {redirect_addr[31:2], 2'b00}; id_valid <= 0; hold buffer discarded.
REQ-026 Redirect in FETCH or HOLD: next state FETCH, no request issued in the redirect cycle.
REQ-027 Redirect in WAIT without rsp that cycle: set kill, stay WAIT; next response discarded, kill cleared, go FETCH.
REQ-028 Redirect in WAIT with rsp in the same cycle: response discarded, kill stays clear, go FETCH.
REQ-029 Redirect in the same cycle as id_valid & id_ready: consumption counts, IF/ID still flushed.
REQ-030 imem_rsp_valid in FETCH or HOLD (stale or spurious) SHALL be ignored.
REQ-031 id_params SHALL hold value while id_valid=1 and id_ready=0.

Reset
REQ-032 While rst_n=0 at a clock edge: pc <= RESET_VECTOR, state <= FETCH, kill <= 0, id_valid <= 0, id_params <= 0, hold buffer <= 0.
REQ-033 imem_req_valid SHALL be 0 in any cycle where rst_n=0.
REQ-034 Reset mid-WAIT SHALL abandon the outstanding request; its late response is ignored per REQ-030.
REQ-035 First cycle after release: imem_req_valid=1, imem_req_addr=RESET_VECTOR.

Verification
REQ-036 Reset release, ready=1, rsp one cycle after accept, id_ready=1, data 32'h11,22,33 -> id_params {32'h11,4},{32'h22,8},{32'h33,12} on consecutive instructions, requests to 0,4,8.
REQ-037 id_ready=0 for 5 cycles after first instruction -> IF/ID holds {32'h11,4}, second word in HOLD, no third request; id_ready=1 -> {32'h22,8} next cycle, then request to 8.
REQ-038 Redirect to 32'h100 while WAIT for addr 4 -> response for 4 dropped, id_valid=0, next request addr 32'h100, then id_params {data,32'h104}.
REQ-039 Redirect to 32'h203 in same cycle as rsp -> rsp discarded, next request addr 32'h200.
REQ-040 RESET_VECTOR=32'hFFFF_FFFC -> first id_params.ia_plus_4 = 0, next request addr 0.
REQ-041 rst_n low during WAIT, late rsp_valid after release in FETCH -> ignored, id_valid stays 0, request to RESET_VECTOR.
